// File: rtl/eriscv_rst_ctrl.sv
// Reset controller for eriscv_min_sopc: synchronised board-reset release, programmable hold,
// staggered per-channel release, and software/watchdog re-reset with a cause register.
module eriscv_rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_CH      = 2,
    parameter int STAGGER     = 4,
    parameter int WDT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_rst_req,
    input  logic                 wdt_en,
    input  logic                 wdt_kick,
    input  logic [WDT_WIDTH-1:0] wdt_load,
    output logic [NUM_CH-1:0]    rst_out,
    output logic                 rst_done,
    output logic [1:0]           rst_cause,
    output logic                 wdt_expired
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CH_W-1:0]        r_ch;
    logic [NUM_CH-1:0]      r_rst_out;
    logic                   r_rst_done;
    logic [1:0]             r_rst_cause;
    logic                   r_wdt_expired;
    logic [WDT_WIDTH-1:0]   r_wdt_cnt;

    logic w_rst_n_sync;
    logic w_in_run;
    logic w_wdt_active;
    logic w_expire;
    logic w_sw;
    logic w_rerst;

    assign w_rst_n_sync = r_sync[SYNC_STAGES-1];
    assign w_in_run     = (r_state == S_RUN);
    assign w_wdt_active = w_in_run && wdt_en;
    assign w_expire     = w_wdt_active && !wdt_kick && (r_wdt_cnt == '0);
    assign w_sw         = w_in_run && sw_rst_req;
    assign w_rerst      = w_sw || w_expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Channels release lowest index first: shifting a zero in from bit 0 clears them in order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_HOLD;
            r_cnt         <= '0;
            r_ch          <= '0;
            r_rst_out     <= '1;
            r_rst_done    <= 1'b0;
            r_rst_cause   <= CAUSE_POR;
            r_wdt_expired <= 1'b0;
        end else begin
            r_wdt_expired <= w_expire;
            if (w_rerst) begin
                r_state     <= S_HOLD;
                r_cnt       <= '0;
                r_ch        <= '0;
                r_rst_out   <= '1;
                r_rst_done  <= 1'b0;
                r_rst_cause <= w_sw ? CAUSE_SW : CAUSE_WDT;
            end else begin
                case (r_state)
                    S_HOLD: begin
                        if (!w_rst_n_sync) begin
                            r_cnt <= '0;
                        end else if (r_cnt == HOLD_LAST) begin
                            r_rst_out <= r_rst_out << 1;
                            r_cnt     <= '0;
                            if (NUM_CH == 1) begin
                                r_state    <= S_RUN;
                                r_rst_done <= 1'b1;
                            end else begin
                                r_state <= S_RELEASE;
                                r_ch    <= CH_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_RELEASE: begin
                        if (r_cnt == STAG_LAST) begin
                            r_rst_out <= r_rst_out << 1;
                            r_cnt     <= '0;
                            if (r_ch == LAST_CH) begin
                                r_state    <= S_RUN;
                                r_rst_done <= 1'b1;
                            end else begin
                                r_ch <= r_ch + CH_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        r_cnt <= '0;
                    end
                    default: begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Watchdog reloads whenever it is not actively counting, so RUN always starts from wdt_load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdt_cnt <= '0;
        end else if (!w_wdt_active || wdt_kick || w_expire) begin
            r_wdt_cnt <= wdt_load;
        end else begin
            r_wdt_cnt <= r_wdt_cnt - WDT_WIDTH'(1);
        end
    end

    assign rst_out     = r_rst_out;
    assign rst_done    = r_rst_done;
    assign rst_cause   = r_rst_cause;
    assign wdt_expired = r_wdt_expired;

endmodule

// File: tb/tb_eriscv_rst_ctrl.sv
// Directed bench for eriscv_rst_ctrl: default instance plus a single-channel, short-hold instance
// sharing clock and board reset.
module tb_eriscv_rst_ctrl;

    logic        clk;
    logic        rst;
    logic        swRstReq;
    logic        wdtEn;
    logic        wdtKick;
    logic [15:0] wdtLoad;
    logic [1:0]  rstOut;
    logic        rstDone;
    logic [1:0]  rstCause;
    logic        wdtExpired;

    logic [0:0]  pRstOut;
    logic        pRstDone;
    logic [1:0]  pRstCause;
    logic        pWdtExpired;

    int testCount = 0;
    int failCount = 0;
    int pulseCount;

    eriscv_rst_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .sw_rst_req  (swRstReq),
        .wdt_en      (wdtEn),
        .wdt_kick    (wdtKick),
        .wdt_load    (wdtLoad),
        .rst_out     (rstOut),
        .rst_done    (rstDone),
        .rst_cause   (rstCause),
        .wdt_expired (wdtExpired)
    );

    eriscv_rst_ctrl #(
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1),
        .NUM_CH      (1),
        .STAGGER     (1),
        .WDT_WIDTH   (16)
    ) dutP (
        .clk         (clk),
        .rst         (rst),
        .sw_rst_req  (1'b0),
        .wdt_en      (1'b0),
        .wdt_kick    (1'b0),
        .wdt_load    (16'd0),
        .rst_out     (pRstOut),
        .rst_done    (pRstDone),
        .rst_cause   (pRstCause),
        .wdt_expired (pWdtExpired)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic sw, input logic en, input logic kick);
        swRstReq = sw;
        wdtEn    = en;
        wdtKick  = kick;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge 1 is the first rising clock edge after rst goes high.
    task automatic runReleaseSeq(input string phase);
        logic [1:0] expOut;
        for (int e = 1; e <= 22; e++) begin
            tick();
            expOut = {(e < 22) ? 1'b1 : 1'b0, (e < 18) ? 1'b1 : 1'b0};
            checkOutput($sformatf("%s rst_out e%0d", phase, e), 32'(rstOut), 32'(expOut));
            checkOutput($sformatf("%s rst_done e%0d", phase, e), 32'(rstDone), (e >= 22) ? 32'd1 : 32'd0);
            if (e <= 5) begin
                checkOutput($sformatf("%s p rst_out e%0d", phase, e), 32'(pRstOut), (e < 4) ? 32'd1 : 32'd0);
                checkOutput($sformatf("%s p rst_done e%0d", phase, e), 32'(pRstDone), (e >= 4) ? 32'd1 : 32'd0);
            end
        end
        checkOutput({phase, " rst_cause"}, 32'(rstCause), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        wdtLoad = 16'd5;
        applyStimulus(1'b0, 1'b0, 1'b0);

        #105;
        checkOutput("reset rst_out", 32'(rstOut), 32'h3);
        checkOutput("reset rst_done", 32'(rstDone), 32'd0);
        checkOutput("reset rst_cause", 32'(rstCause), 32'd0);
        checkOutput("reset wdt_expired", 32'(wdtExpired), 32'd0);
        checkOutput("reset p rst_out", 32'(pRstOut), 32'd1);

        #90;
        rst = 1'b1;
        runReleaseSeq("poweron");

        // Software reset, with the watchdog armed during the resulting hold.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("sw rst_out", 32'(rstOut), 32'h3);
        checkOutput("sw rst_done", 32'(rstDone), 32'd0);
        checkOutput("sw rst_cause", 32'(rstCause), 32'd1);
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (j == 15) checkOutput("sw rst_out +15", 32'(rstOut), 32'h3);
            if (j == 16) checkOutput("sw rst_out +16", 32'(rstOut), 32'h2);
            if (j == 19) checkOutput("sw rst_out +19", 32'(rstOut), 32'h2);
            if (j == 20) checkOutput("sw rst_out +20", 32'(rstOut), 32'h0);
            if (j == 20) checkOutput("sw rst_done +20", 32'(rstDone), 32'd1);
        end
        checkOutput("sw rst_cause held", 32'(rstCause), 32'd1);

        for (int j = 1; j <= 5; j++) begin
            tick();
            checkOutput($sformatf("wdt quiet run%0d", j), 32'(wdtExpired), 32'd0);
        end
        checkOutput("wdt rst_out before expiry", 32'(rstOut), 32'h0);
        tick();
        checkOutput("wdt expired pulse", 32'(wdtExpired), 32'd1);
        checkOutput("wdt rst_out", 32'(rstOut), 32'h3);
        checkOutput("wdt rst_done", 32'(rstDone), 32'd0);
        checkOutput("wdt rst_cause", 32'(rstCause), 32'd2);
        tick();
        checkOutput("wdt pulse ends", 32'(wdtExpired), 32'd0);

        pulseCount = 0;
        for (int i = 0; i < 140; i++) begin
            wdtKick = (i % 4 == 0);
            tick();
            if (wdtExpired) pulseCount++;
        end
        wdtKick = 1'b0;
        checkOutput("kick no expiry", 32'(pulseCount), 32'd0);
        checkOutput("kick rst_done", 32'(rstDone), 32'd1);
        checkOutput("kick rst_cause", 32'(rstCause), 32'd2);

        // Collision: software request lands on the watchdog expiry edge.
        wdtKick = 1'b1;
        tick();
        wdtKick = 1'b0;
        repeat (5) tick();
        checkOutput("coll pre wdt_expired", 32'(wdtExpired), 32'd0);
        checkOutput("coll pre rst_out", 32'(rstOut), 32'h0);
        swRstReq = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("coll wdt_expired", 32'(wdtExpired), 32'd1);
        checkOutput("coll rst_cause", 32'(rstCause), 32'd1);
        checkOutput("coll rst_out", 32'(rstOut), 32'h3);
        checkOutput("coll rst_done", 32'(rstDone), 32'd0);
        pulseCount = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (wdtExpired) pulseCount++;
            if (j == 15) checkOutput("coll rst_out +15", 32'(rstOut), 32'h3);
            if (j == 16) checkOutput("coll rst_out +16", 32'(rstOut), 32'h2);
            if (j == 20) checkOutput("coll rst_out +20", 32'(rstOut), 32'h0);
        end
        checkOutput("coll single pulse", 32'(pulseCount), 32'd0);
        checkOutput("coll rst_done", 32'(rstDone), 32'd1);
        checkOutput("coll rst_cause held", 32'(rstCause), 32'd1);

        // Board reset glitch while channel 1 is still held.
        swRstReq = 1'b1;
        tick();
        swRstReq = 1'b0;
        repeat (17) tick();
        checkOutput("glitch pre rst_out", 32'(rstOut), 32'h2);
        rst = 1'b0;
        #1;
        checkOutput("glitch async rst_out", 32'(rstOut), 32'h3);
        checkOutput("glitch async rst_cause", 32'(rstCause), 32'd0);
        checkOutput("glitch async p rst_out", 32'(pRstOut), 32'd1);
        #2;
        rst = 1'b1;
        runReleaseSeq("glitch");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
